// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter:
// FSM state encoding, read-latency tag layout and 32-bit beat slicing.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_BEAT0,
    D_BEAT1,
    F_ISSUE,
    RD_WAIT,
    DONE
  } arb_state_t;

  localparam logic BEAT0 = 1'b0;
  localparam logic BEAT1 = 1'b1;

  // Travels with every read strobe so the returning word lands in the right place.
  typedef struct packed {
    logic fetch;
    logic beat;
    logic squash;
  } lat_tag_t;

  function automatic logic [15:0] BEAT_HI(input logic [31:0] w);
    return w[31:16];
  endfunction

  function automatic logic [15:0] BEAT_LO(input logic [31:0] w);
    return w[15:0];
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Fixed-depth valid/tag delay line matching the memory read latency; its
// output marks the cycle in which m_rdata belongs to a given read strobe.
module rd_lat_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  lat_tag_t push_tag,
  output logic     out_vld,
  output lat_tag_t out_tag
);

  logic     vld_p [RD_LAT];
  lat_tag_t tag_p [RD_LAT];

  // Stage 0 loads at the strobe edge; stage RD_LAT-1 lines up with m_rdata
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_p[i] <= 1'b0;
        tag_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= push;
      tag_p[0] <= push_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign out_vld = vld_p[RD_LAT-1];
  assign out_tag = tag_p[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port 16-bit memory between fetch and the memory stage,
// splitting 32-bit transfers into two beats and generating pipeline stalls.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 20,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          f_flush,
  output logic [15:0]   f_rdata,
  output logic          f_valid,
  output logic          f_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_wide,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_done,
  output logic          d_busy,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [15:0]   m_wdata,
  input  logic [15:0]   m_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic          cur_fetch;
  logic          fetch_squash;
  logic [31:0]   d_rdata_q;
  logic [15:0]   f_rdata_q;
  logic          grant_d, grant_f;
  logic          fetch_ok, force_fetch;
  logic          push;
  lat_tag_t      push_tag, out_tag;
  logic          out_vld, cap_final;

  // A flush in the request cycle makes the fetch ineligible, even when starved.
  assign fetch_ok    = f_req & ~f_flush;
  assign force_fetch = fetch_ok & (starve_cnt == SW'(STARVE_MAX));
  assign cap_final   = out_vld & (out_tag.fetch | ~d_wide | (out_tag.beat == BEAT1));

  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag (push_tag),
    .out_vld  (out_vld),
    .out_tag  (out_tag)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    push      = 1'b0;
    push_tag  = '0;
    d_done    = 1'b0;
    f_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !force_fetch) begin
          grant_d   = 1'b1;
          state_nxt = D_BEAT0;
        end else if (fetch_ok) begin
          grant_f   = 1'b1;
          state_nxt = F_ISSUE;
        end
      end
      D_BEAT0: begin
        m_en          = 1'b1;
        m_we          = d_we;
        m_addr        = d_addr;
        // Upper half goes first on a two-beat transfer
        if (d_we) m_wdata = d_wide ? BEAT_HI(d_wdata) : BEAT_LO(d_wdata);
        push          = ~d_we;
        push_tag.beat = BEAT0;
        if (d_wide)    state_nxt = D_BEAT1;
        else if (d_we) state_nxt = DONE;
        else           state_nxt = RD_WAIT;
      end
      D_BEAT1: begin
        m_en          = 1'b1;
        m_we          = d_we;
        m_addr        = d_addr + AW'(1);
        if (d_we) m_wdata = BEAT_LO(d_wdata);
        push          = ~d_we;
        push_tag.beat = BEAT1;
        state_nxt     = d_we ? DONE : RD_WAIT;
      end
      F_ISSUE: begin
        m_en            = 1'b1;
        m_addr          = f_addr;
        push            = 1'b1;
        push_tag.fetch  = 1'b1;
        push_tag.squash = f_flush;
        state_nxt       = RD_WAIT;
      end
      RD_WAIT: begin
        if (cap_final) state_nxt = DONE;
      end
      DONE: begin
        d_done    = ~cur_fetch;
        f_valid   = cur_fetch & ~fetch_squash & ~f_flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt   <= '0;
      cur_fetch    <= 1'b0;
      fetch_squash <= 1'b0;
    end else begin
      if (grant_d) begin
        cur_fetch <= 1'b0;
        if (f_req && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
      end
      if (grant_f) begin
        cur_fetch  <= 1'b1;
        starve_cnt <= '0;
      end
      // A redirect anywhere in the fetch's lifetime kills its f_valid pulse
      if (state == IDLE) fetch_squash <= 1'b0;
      else if (cur_fetch && (f_flush || (out_vld && out_tag.fetch && out_tag.squash)))
        fetch_squash <= 1'b1;
    end
  end

  // Capture stage: m_rdata is steered by the tag emerging from the latency pipe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_rdata_q <= '0;
      f_rdata_q <= '0;
    end else if (out_vld) begin
      if (out_tag.fetch)               f_rdata_q         <= m_rdata;
      else if (!d_wide)                d_rdata_q         <= {16'h0000, m_rdata};
      else if (out_tag.beat == BEAT0)  d_rdata_q[31:16]  <= m_rdata;
      else                             d_rdata_q[15:0]   <= m_rdata;
    end
  end

  assign d_rdata = d_rdata_q;
  assign f_rdata = f_rdata_q;
  // Stalls are held low while reset is asserted so every output reads 0.
  assign f_stall = reset & f_req & ~f_valid;
  assign d_busy  = reset & d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one RD_LAT=1 instance for most cases and
// an RD_LAT=3 instance for the long-latency read, each with a small memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, f_flush, d_req, d_we, d_wide;
  logic [19:0] f_addr, d_addr;
  logic [31:0] d_wdata;
  logic [15:0] f_rdata, m_wdata, m_rdata;
  logic        f_valid, f_stall, d_done, d_busy, m_en, m_we;
  logic [31:0] d_rdata;
  logic [19:0] m_addr;

  logic        f_req3, d_req3;
  logic [15:0] f_rdata3, m_wdata3, m_rdata3;
  logic        f_valid3, f_stall3, d_done3, d_busy3, m_en3, m_we3;
  logic [31:0] d_rdata3;
  logic [19:0] m_addr3;

  logic [15:0] rq1 [1];
  logic [15:0] rq3 [3];

  int n_checks = 0;
  int n_errors = 0;
  logic d_hold = 1'b0;
  logic f_hold = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(20), .RD_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_rdata(f_rdata), .f_valid(f_valid), .f_stall(f_stall),
    .d_req(d_req), .d_we(d_we), .d_wide(d_wide), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_busy(d_busy),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  mem_port_arbiter #(.AW(20), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .reset(reset),
    .f_req(f_req3), .f_addr(f_addr), .f_flush(f_flush),
    .f_rdata(f_rdata3), .f_valid(f_valid3), .f_stall(f_stall3),
    .d_req(d_req3), .d_we(d_we), .d_wide(d_wide), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata3), .d_done(d_done3), .d_busy(d_busy3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3)
  );

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    if (a == 20'hFFFFF)      return 16'h1234;
    else if (a == 20'h00000) return 16'h5678;
    else                     return a[15:0] ^ 16'hA5A5;
  endfunction

  // Pipelined memory: word for a strobe in cycle c is presented in cycle c+RD_LAT
  always @(posedge clk) begin
    rq1[0] <= (m_en && !m_we) ? mem_word(m_addr) : 16'hDEAD;
    rq3[2] <= rq3[1];
    rq3[1] <= rq3[0];
    rq3[0] <= (m_en3 && !m_we3) ? mem_word(m_addr3) : 16'hDEAD;
  end
  assign m_rdata  = rq1[0];
  assign m_rdata3 = rq3[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Requesters must hold until their completion (or a fetch flush)
  always @(posedge clk) begin
    if (!reset) begin
      d_hold = 1'b0;
      f_hold = 1'b0;
    end else begin
      if (d_hold) check_eq("d_req_held", {31'b0, d_req}, 32'd1);
      if (f_hold) check_eq("f_req_held", {31'b0, f_req}, 32'd1);
      d_hold = d_req && !d_done;
      f_hold = f_req && !f_valid && !f_flush;
    end
  end

  initial begin
    int ph;
    reset = 1'b0;
    f_req = 1'b1; d_req = 1'b1; f_flush = 1'b0;
    d_we = 1'b0; d_wide = 1'b0; f_addr = '0; d_addr = '0; d_wdata = '0;
    f_req3 = 1'b0; d_req3 = 1'b0;

    // Reset state, with both requests raised to show stalls are held low
    #2;
    check_eq("rst_m_en", {31'b0, m_en}, 32'd0);
    check_eq("rst_m_we", {31'b0, m_we}, 32'd0);
    check_eq("rst_m_addr", {12'b0, m_addr}, 32'd0);
    check_eq("rst_m_wdata", {16'b0, m_wdata}, 32'd0);
    check_eq("rst_d_done", {31'b0, d_done}, 32'd0);
    check_eq("rst_f_valid", {31'b0, f_valid}, 32'd0);
    check_eq("rst_d_busy", {31'b0, d_busy}, 32'd0);
    check_eq("rst_f_stall", {31'b0, f_stall}, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);
    check_eq("rst_f_rdata", {16'b0, f_rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    f_req = 1'b0; d_req = 1'b0;
    reset = 1'b1;
    cyc();

    // 1: narrow write
    d_req = 1'b1; d_we = 1'b1; d_wide = 1'b0; d_addr = 20'h00100; d_wdata = 32'h0000ABCD;
    @(negedge clk);
    check_eq("t1_T_m_en", {31'b0, m_en}, 32'd0);
    check_eq("t1_T_busy", {31'b0, d_busy}, 32'd1);
    cyc(); @(negedge clk);
    check_eq("t1_m_en", {31'b0, m_en}, 32'd1);
    check_eq("t1_m_we", {31'b0, m_we}, 32'd1);
    check_eq("t1_m_addr", {12'b0, m_addr}, 32'h00100);
    check_eq("t1_m_wdata", {16'b0, m_wdata}, 32'hABCD);
    check_eq("t1_T1_done", {31'b0, d_done}, 32'd0);
    cyc(); @(negedge clk);
    check_eq("t1_done", {31'b0, d_done}, 32'd1);
    check_eq("t1_busy_done", {31'b0, d_busy}, 32'd0);
    check_eq("t1_T2_m_en", {31'b0, m_en}, 32'd0);
    cyc();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check_eq("t1_T3_done", {31'b0, d_done}, 32'd0);
    cyc();

    // 2: wide read across the top of the address space
    d_req = 1'b1; d_we = 1'b0; d_wide = 1'b1; d_addr = 20'hFFFFF; d_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    check_eq("t2_T_m_en", {31'b0, m_en}, 32'd0);
    cyc(); @(negedge clk);
    check_eq("t2_b0_m_en", {31'b0, m_en}, 32'd1);
    check_eq("t2_b0_m_we", {31'b0, m_we}, 32'd0);
    check_eq("t2_b0_addr", {12'b0, m_addr}, 32'hFFFFF);
    check_eq("t2_b0_wdata", {16'b0, m_wdata}, 32'd0);
    cyc(); @(negedge clk);
    check_eq("t2_b1_m_en", {31'b0, m_en}, 32'd1);
    check_eq("t2_b1_addr", {12'b0, m_addr}, 32'h00000);
    check_eq("t2_b1_wdata", {16'b0, m_wdata}, 32'd0);
    cyc(); @(negedge clk);
    check_eq("t2_wait_m_en", {31'b0, m_en}, 32'd0);
    check_eq("t2_wait_done", {31'b0, d_done}, 32'd0);
    cyc(); @(negedge clk);
    check_eq("t2_done", {31'b0, d_done}, 32'd1);
    check_eq("t2_rdata", d_rdata, 32'h12345678);
    cyc();
    d_req = 1'b0; d_wide = 1'b0;
    cyc();

    // 3: contention, 4 data grants then one forced fetch, 16-cycle period
    for (int c = 0; c < 32; c++) begin
      f_req = 1'b1; f_addr = 20'h00040;
      d_req = (c <= 27); d_we = 1'b1; d_addr = 20'h00200; d_wdata = 32'h00001111;
      @(negedge clk);
      ph = c % 16;
      check_eq("t3_m_en", {31'b0, m_en}, {31'b0, (ph == 1 || ph == 4 || ph == 7 || ph == 10 || ph == 13)});
      if (m_en) begin
        check_eq("t3_m_we", {31'b0, m_we}, {31'b0, (ph != 13)});
        check_eq("t3_m_addr", {12'b0, m_addr}, (ph == 13) ? 32'h00040 : 32'h00200);
      end
      check_eq("t3_d_done", {31'b0, d_done}, {31'b0, (ph == 2 || ph == 5 || ph == 8 || ph == 11)});
      check_eq("t3_f_valid", {31'b0, f_valid}, {31'b0, (ph == 15)});
      check_eq("t3_f_stall", {31'b0, f_stall}, {31'b0, (ph != 15)});
      if (ph == 15) check_eq("t3_f_rdata", {16'b0, f_rdata}, 32'hA5E5);
      cyc();
    end
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    cyc();

    // 4: flush with the request blocks the grant; flush in RD_WAIT squashes f_valid
    f_req = 1'b1; f_flush = 1'b1; f_addr = 20'h00020;
    @(negedge clk);
    check_eq("t4_A_m_en", {31'b0, m_en}, 32'd0);
    cyc();
    f_flush = 1'b0;
    @(negedge clk);
    check_eq("t4_T_m_en", {31'b0, m_en}, 32'd0);
    cyc(); @(negedge clk);
    check_eq("t4_issue_m_en", {31'b0, m_en}, 32'd1);
    check_eq("t4_issue_m_we", {31'b0, m_we}, 32'd0);
    check_eq("t4_issue_addr", {12'b0, m_addr}, 32'h00020);
    cyc();
    f_flush = 1'b1;
    @(negedge clk);
    check_eq("t4_wait_m_en", {31'b0, m_en}, 32'd0);
    check_eq("t4_wait_valid", {31'b0, f_valid}, 32'd0);
    cyc();
    f_flush = 1'b0; f_req = 1'b0;
    @(negedge clk);
    check_eq("t4_done_valid", {31'b0, f_valid}, 32'd0);
    check_eq("t4_done_stall", {31'b0, f_stall}, 32'd0);
    cyc();
    f_req = 1'b1; f_addr = 20'h00030;
    @(negedge clk);
    check_eq("t4_idle_m_en", {31'b0, m_en}, 32'd0);
    check_eq("t4_idle_valid", {31'b0, f_valid}, 32'd0);
    cyc(); @(negedge clk);
    check_eq("t4_re_m_en", {31'b0, m_en}, 32'd1);
    check_eq("t4_re_addr", {12'b0, m_addr}, 32'h00030);
    cyc(); @(negedge clk);
    check_eq("t4_re_wait_valid", {31'b0, f_valid}, 32'd0);
    cyc(); @(negedge clk);
    check_eq("t4_re_valid", {31'b0, f_valid}, 32'd1);
    check_eq("t4_re_rdata", {16'b0, f_rdata}, 32'hA595);
    cyc();
    f_req = 1'b0;
    cyc();

    // 5: reset during beat 1 of a wide write, then restart from beat 0
    d_req = 1'b1; d_we = 1'b1; d_wide = 1'b1; d_addr = 20'h00300; d_wdata = 32'hCAFEBEEF;
    cyc(); @(negedge clk);
    check_eq("t5_b0_addr", {12'b0, m_addr}, 32'h00300);
    check_eq("t5_b0_wdata", {16'b0, m_wdata}, 32'hCAFE);
    cyc(); @(negedge clk);
    check_eq("t5_b1_addr", {12'b0, m_addr}, 32'h00301);
    check_eq("t5_b1_wdata", {16'b0, m_wdata}, 32'hBEEF);
    #1 reset = 1'b0;
    #1;
    check_eq("t5_rst_m_en", {31'b0, m_en}, 32'd0);
    check_eq("t5_rst_m_we", {31'b0, m_we}, 32'd0);
    check_eq("t5_rst_m_addr", {12'b0, m_addr}, 32'd0);
    check_eq("t5_rst_m_wdata", {16'b0, m_wdata}, 32'd0);
    check_eq("t5_rst_done", {31'b0, d_done}, 32'd0);
    check_eq("t5_rst_busy", {31'b0, d_busy}, 32'd0);
    check_eq("t5_rst_rdata", d_rdata, 32'd0);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_R_m_en", {31'b0, m_en}, 32'd0);
    check_eq("t5_R_done", {31'b0, d_done}, 32'd0);
    cyc(); @(negedge clk);
    check_eq("t5_R1_m_en", {31'b0, m_en}, 32'd1);
    check_eq("t5_R1_addr", {12'b0, m_addr}, 32'h00300);
    check_eq("t5_R1_wdata", {16'b0, m_wdata}, 32'hCAFE);
    cyc(); @(negedge clk);
    check_eq("t5_R2_addr", {12'b0, m_addr}, 32'h00301);
    check_eq("t5_R2_done", {31'b0, d_done}, 32'd0);
    cyc(); @(negedge clk);
    check_eq("t5_R3_done", {31'b0, d_done}, 32'd1);
    cyc();
    d_req = 1'b0; d_we = 1'b0; d_wide = 1'b0;
    cyc();

    // 6: RD_LAT=3 narrow read on the second instance
    d_req3 = 1'b1; d_we = 1'b0; d_wide = 1'b0; d_addr = 20'h00500;
    @(negedge clk);
    check_eq("t6_T_m_en", {31'b0, m_en3}, 32'd0);
    cyc();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_eq("t6_m_en", {31'b0, m_en3}, {31'b0, (k == 1)});
      check_eq("t6_d_done", {31'b0, d_done3}, {31'b0, (k == 5)});
      check_eq("t6_d_busy", {31'b0, d_busy3}, {31'b0, (k != 5)});
      check_eq("t6_f_valid", {31'b0, f_valid3}, 32'd0);
      check_eq("t6_f_stall", {31'b0, f_stall3}, 32'd0);
      if (k == 1) begin
        check_eq("t6_m_addr", {12'b0, m_addr3}, 32'h00500);
        check_eq("t6_m_we", {31'b0, m_we3}, 32'd0);
        check_eq("t6_m_wdata", {16'b0, m_wdata3}, 32'd0);
      end
      if (k == 5) begin
        check_eq("t6_d_rdata", d_rdata3, 32'h0000A0A5);
        check_eq("t6_f_rdata", {16'b0, f_rdata3}, 32'd0);
      end
      cyc();
    end
    d_req3 = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
